mem_access_unit: RTL and testbench

Load/store front end placed between the execute stage and the word-addressed data memory. It accepts one byte, halfword or word access per request. It performs sign or zero extension for loads and does a read-modify-write for sub-word stores. It also rejects misaligned or out-of-range addresses before they reach memory. The memory port it drives is 32-bit, word-indexed by addr[31:2], with combinational read and a synchronous write on posedge clk.

---
 rtl/mem_access_unit.sv | 169 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front end between the execute stage and the word-indexed data memory.
// Extends sub-word loads, performs read-modify-write for sub-word stores, and rejects bad addresses.
module mem_access_unit #(
    parameter int unsigned DATA_MEM_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        out_of_range,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_write_data,
    output logic        dm_mem_write,
    input  logic [31:0] dm_read_data
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStore,
        StErr,
        StRmwRd,
        StRmwWr
    } state_e;

    state_e      state_q;
    logic [1:0]  size_q;
    logic        sign_ext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        misaligned_in;
    logic        out_of_range_in;

    function automatic logic calc_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic r;
        case (sz)
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            default: r = (off != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic calc_out_of_range(input logic [31:0] a);
        return {2'b00, a[31:2]} >= DATA_MEM_SIZE;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                 input logic [1:0] off, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = {{24{sext & b[7]}}, b};
            2'b01:   r = {{16{sext & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] off, input logic [15:0] wd);
        logic [31:0] r;
        r = word;
        if (sz == 2'b00) begin
            r[{off, 3'b000} +: 8] = wd[7:0];
        end else begin
            r[{off[1], 4'b0000} +: 16] = wd;
        end
        return r;
    endfunction

    assign misaligned_in   = calc_misaligned(size, addr[1:0]);
    assign out_of_range_in = calc_out_of_range(addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            size_q       <= 2'b00;
            sign_ext_q   <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            rdata        <= 32'h0;
            done         <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            done         <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        size_q     <= size;
                        sign_ext_q <= sign_ext;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        if (misaligned_in || out_of_range_in) begin
                            state_q <= StErr;
                        end else if (!we) begin
                            state_q <= StLoad;
                        end else if (size[1]) begin
                            state_q <= StStore;
                        end else begin
                            state_q <= StRmwRd;
                        end
                    end
                end
                StLoad: begin
                    rdata   <= extract_lane(dm_read_data, size_q, addr_q[1:0], sign_ext_q);
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                StStore: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                StErr: begin
                    misaligned   <= calc_misaligned(size_q, addr_q[1:0]);
                    out_of_range <= calc_out_of_range(addr_q);
                    done         <= 1'b1;
                    state_q      <= StIdle;
                end
                StRmwRd: begin
                    merge_q <= dm_read_data;
                    state_q <= StRmwWr;
                end
                StRmwWr: begin
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign dm_addr = busy ? {addr_q[31:2], 2'b00} : 32'h0;

    always_comb begin
        dm_mem_write  = 1'b0;
        dm_write_data = 32'h0;
        case (state_q)
            StStore: begin
                dm_mem_write  = 1'b1;
                dm_write_data = wdata_q;
            end
            StRmwWr: begin
                dm_mem_write  = 1'b1;
                dm_write_data = merge_lane(merge_q, size_q, addr_q[1:0], wdata_q[15:0]);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random traffic
// checked against a byte-arithmetic reference model of the memory.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misaligned, out_of_range, dm_mem_write;
    logic [31:0] rdata, dm_addr, dm_write_data, dm_read_data;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic [31:0] exp_rdata = 32'h0;
    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    mem_access_unit #(.DATA_MEM_SIZE(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .we           (we),
        .size         (size),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .dm_addr      (dm_addr),
        .dm_write_data(dm_write_data),
        .dm_mem_write (dm_mem_write),
        .dm_read_data (dm_read_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E3779B1 + 32'h0BADF00D;
    endfunction

    // Attached data memory: combinational read, synchronous write.
    assign dm_read_data = (dm_addr[31:8] == 24'h0) ? mem[dm_addr[7:2]] : 32'h0;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (dm_mem_write && dm_addr[31:8] == 24'h0) begin
            mem[dm_addr[7:2]] <= dm_write_data;
        end
        if (dm_mem_write) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic logic [31:0] model_load(input logic [31:0] word, input int sz,
                                               input logic sx, input int off);
        logic [31:0] v;
        if (sz >= 2) return word;
        if (sz == 0) begin
            v = (word >> (8 * off)) % 256;
            if (sx && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = (word >> (8 * (off / 2 * 2))) % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input int sz,
                                                input int off, input logic [31:0] wd);
        logic [31:0] lane_mask;
        int          boff;
        if (sz >= 2) return wd;
        lane_mask = (sz == 0) ? 32'hFF : 32'hFFFF;
        boff      = (sz == 0) ? off : off / 2 * 2;
        return (old & ~(lane_mask << (8 * boff))) | ((wd & lane_mask) << (8 * boff));
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen
    // (lat = negedges after accept), or lat = 0 if done never came.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, output int lat);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        lat = 0;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req = 1'b0; size = ~sz; sign_ext = ~sx; addr = a ^ 32'h4; wdata = ~wd;
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, misaligned, out_of_range, dm_mem_write} !== 5'b0 || rdata !== 32'h0 ||
            dm_addr !== 32'h0 || dm_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b mis=%b oor=%b wr=%b rdata=%h dm_addr=%h wd=%h, required all 0",
                     busy, done, misaligned, out_of_range, dm_mem_write, rdata, dm_addr, dm_write_data);
        end
        rst = 1'b0;
        fill = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        int lat, w0;
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat);
        ref_mem[4] = 32'hDEADBEEF;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL word_store_latency: got %0d required 2", lat); end
        checks++;
        if (wr_cnt - w0 !== 1) begin
            errors++; $display("FAIL word_store_write_cycles: got %0d required 1", wr_cnt - w0);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_store_mem: got %h required deadbeef", mem[4]);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat);
        exp_rdata = 32'hDEADBEEF;
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL word_load_latency: got %0d required 2", lat); end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_load_rdata: got %h required deadbeef", rdata);
        end
    endtask

    task automatic test_subword();
        int lat;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL byte_store_latency: got %0d required 3", lat); end
        checks++;
        if (mem[4] !== 32'h1122AA44) begin
            errors++; $display("FAIL byte_store_mem: got %h required 1122aa44", mem[4]);
        end
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, lat);
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD5566, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL half_store_latency: got %0d required 3", lat); end
        checks++;
        if (mem[4] !== 32'h55663344) begin
            errors++; $display("FAIL half_store_mem: got %h required 55663344", mem[4]);
        end
        ref_mem[4] = 32'h55663344;
    endtask

    task automatic test_extension();
        int lat;
        issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F07F81, lat);
        ref_mem[8] = 32'h80F07F81;
        issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, lat);
        checks++;
        if (rdata !== 32'hFFFFFF81) begin
            errors++; $display("FAIL load_byte_sext: got %h required ffffff81", rdata);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, lat);
        checks++;
        if (rdata !== 32'h0000007F) begin
            errors++; $display("FAIL load_byte_zext: got %h required 0000007f", rdata);
        end
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, lat);
        checks++;
        if (rdata !== 32'hFFFF80F0) begin
            errors++; $display("FAIL load_half_sext: got %h required ffff80f0", rdata);
        end
        exp_rdata = 32'hFFFF80F0;
    endtask

    task automatic test_errors();
        int lat, w0;
        issue(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, lat);
        checks++;
        if ({misaligned, out_of_range} !== 2'b10 || lat !== 2) begin
            errors++; $display("FAIL err_misaligned_flags: got mis=%b oor=%b lat=%0d required 1 0 2",
                               misaligned, out_of_range, lat);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++; $display("FAIL err_rdata_held: got %h required %h", rdata, exp_rdata);
        end
        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, lat);
        checks++;
        if ({misaligned, out_of_range} !== 2'b01) begin
            errors++; $display("FAIL err_out_of_range_flags: got mis=%b oor=%b required 0 1",
                               misaligned, out_of_range);
        end
        @(negedge clk);
        checks++;
        if (wr_cnt !== w0) begin
            errors++; $display("FAIL err_no_write: got %0d write cycles required 0", wr_cnt - w0);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat);
        checks++;
        if ({misaligned, out_of_range} !== 2'b11) begin
            errors++; $display("FAIL err_both_flags: got mis=%b oor=%b required 1 1",
                               misaligned, out_of_range);
        end
        @(negedge clk);
        checks++;
        if ({done, misaligned, out_of_range} !== 3'b000) begin
            errors++; $display("FAIL err_flags_one_cycle: got done=%b mis=%b oor=%b required 0 0 0",
                               done, misaligned, out_of_range);
        end
    endtask

    task automatic test_back_to_back();
        int lat, d0;
        logic [31:0] v;
        v = $urandom;
        d0 = done_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h44, v, lat);
        ref_mem[17] = v;
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, lat);
        exp_rdata = v;
        checks++;
        if (lat !== 2 || rdata !== v) begin
            errors++; $display("FAIL back_to_back_load: got lat=%0d rdata=%h required 2 %h", lat, rdata, v);
        end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 2) begin
            errors++; $display("FAIL back_to_back_done_count: got %0d required 2", done_cnt - d0);
        end
    endtask

    task automatic test_busy_ignored();
        int d0, w0;
        logic got;
        d0 = done_cnt;
        w0 = wr_cnt;
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h30; wdata = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b required 1", busy); end
        size = 2'b10; addr = 32'h34; wdata = 32'hCAFEF00D;
        @(negedge clk);
        req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        ref_mem[12] = model_store(ref_mem[12], 0, 0, 32'h5A);
        checks++;
        if (got !== 1'b1 || done_cnt - d0 !== 1) begin
            errors++; $display("FAIL busy_single_done: got seen=%b count=%0d required 1 1", got, done_cnt - d0);
        end
        checks++;
        if (wr_cnt - w0 !== 1 || mem[13] !== ref_mem[13]) begin
            errors++; $display("FAIL busy_req_ignored: got writes=%0d mem13=%h required 1 %h",
                               wr_cnt - w0, mem[13], ref_mem[13]);
        end
        checks++;
        if (mem[12] !== ref_mem[12]) begin
            errors++; $display("FAIL busy_first_store: got %h required %h", mem[12], ref_mem[12]);
        end
    endtask

    task automatic test_reset_mid_rmw();
        int d0, lat;
        req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h41; wdata = 32'h77;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_mem_write !== 1'b1) begin
            errors++; $display("FAIL rmw_wr_reached: got dm_mem_write=%b required 1", dm_mem_write);
        end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, misaligned, out_of_range, dm_mem_write} !== 5'b0 || rdata !== 32'h0 ||
            dm_addr !== 32'h0 || dm_write_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b mis=%b oor=%b wr=%b rdata=%h dm_addr=%h wd=%h, required all 0",
                     busy, done, misaligned, out_of_range, dm_mem_write, rdata, dm_addr, dm_write_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (mem[16] !== ref_mem[16] || done_cnt !== d0) begin
            errors++; $display("FAIL reset_mid_dropped: got mem16=%h dones=%0d required %h 0",
                               mem[16], done_cnt - d0, ref_mem[16]);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat);
        exp_rdata = ref_mem[16];
        checks++;
        if (lat !== 2 || rdata !== exp_rdata) begin
            errors++; $display("FAIL reset_recover_load: got lat=%0d rdata=%h required 2 %h", lat, rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        logic        w, sx, exp_mis, exp_oor;
        logic [1:0]  sz;
        logic [31:0] a, wd;
        int          lat, w0, idx, off, exp_lat, exp_wr;
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sx = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
            wd = $urandom;
            idx = int'(a / 4);
            off = int'(a % 4);
            exp_mis = (sz == 2'd1 && off % 2 != 0) || (sz >= 2'd2 && off != 0);
            exp_oor = (idx >= 64);
            exp_lat = 2;
            exp_wr  = 0;
            if (!exp_mis && !exp_oor) begin
                if (!w) begin
                    exp_rdata = model_load(ref_mem[idx], int'(sz), sx, off);
                end else begin
                    ref_mem[idx] = model_store(ref_mem[idx], int'(sz), off, wd);
                    exp_wr = 1;
                    if (sz < 2'd2) exp_lat = 3;
                end
            end
            w0 = wr_cnt;
            issue(w, sz, sx, a, wd, lat);
            checks++;
            if (lat !== exp_lat) begin
                errors++; $display("FAIL rand_latency[%0d]: got %0d required %0d", n, lat, exp_lat);
            end
            checks++;
            if ({misaligned, out_of_range} !== {exp_mis, exp_oor}) begin
                errors++; $display("FAIL rand_flags[%0d]: got mis=%b oor=%b required %b %b",
                                   n, misaligned, out_of_range, exp_mis, exp_oor);
            end
            checks++;
            if (rdata !== exp_rdata) begin
                errors++; $display("FAIL rand_rdata[%0d]: got %h required %h", n, rdata, exp_rdata);
            end
            checks++;
            if (wr_cnt - w0 !== exp_wr) begin
                errors++; $display("FAIL rand_write_cycles[%0d]: got %0d required %0d", n, wr_cnt - w0, exp_wr);
            end
            if (!exp_oor) begin
                checks++;
                if (mem[idx] !== ref_mem[idx]) begin
                    errors++; $display("FAIL rand_mem[%0d]: got %h required %h", n, mem[idx], ref_mem[idx]);
                end
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        test_reset();
        test_word();
        test_subword();
        test_extension();
        test_errors();
        test_back_to_back();
        test_busy_ignored();
        test_reset_mid_rmw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
